button_debounce: RTL and testbench
==================================

Name: button_debounce

Overview:
- Conditioning stage directly upstream of the LED/sequencer control logic.
- Takes the raw active-low breadboard button pin, synchronises it into the clk domain and debounces it.
- Produces a clean level, one-cycle press/release strobes and an optional long-press strobe.
- Downstream blocks consume these strobes instead of sampling the pin directly.

Parameters:
- DEBOUNCE_CYCLES, 270000, cycles the synchronised input must stay stable before a change is accepted (10 ms at 27 MHz); must be >= 1.
- HOLD_CYCLES, 27000000, cycles in PRESSED before long_pulse fires (1 s at 27 MHz); must be >= 1.

Ports:
- clk  input  1  system clock (27 MHz)
- rst  input  1  reset
- bbutton  input  1  raw button pin, active-low (0 = pressed), asynchronous to clk
- pressed  output  1  debounced level, 1 = held
- press_pulse  output  1  one-cycle strobe on accepted press
- release_pulse  output  1  one-cycle strobe on accepted release
- long_pulse  output  1  one-cycle strobe after HOLD_CYCLES held (see Optional Feature)

Interface fixed: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- All state registered on posedge clk. rst is sampled only on posedge clk and overrides everything.
- Reset values:
  - sync flops = 1 (released)
  - FSM = IDLE
  - deb_cnt = 0, hold_cnt = 0, long_done = 0
  - pressed, press_pulse, release_pulse, long_pulse = 0
- Synchroniser: 2-FF chain producing sync_n. No logic touches bbutton before the chain.
- Counter widths: deb_cnt is $clog2(DEBOUNCE_CYCLES+1) bits. hold_cnt is $clog2(HOLD_CYCLES+1) bits. hold_cnt saturates, never wraps.
- FSM states and transitions:
  - IDLE: if sync_n==0, go to PRESS_WAIT with deb_cnt=0.
  - PRESS_WAIT:
    - sync_n==1: back to IDLE (bounce rejected), no strobe.
    - Otherwise deb_cnt++.
    - When deb_cnt==DEBOUNCE_CYCLES-1 and sync_n==0: go to PRESSED; pressed<=1, press_pulse<=1; hold_cnt=0, long_done=0.
  - PRESSED:
    - hold_cnt++ until saturation.
    - When hold_cnt==HOLD_CYCLES-1 and !long_done: long_pulse<=1, long_done<=1.
    - If sync_n==1: go to RELEASE_WAIT with deb_cnt=0; hold_cnt frozen.
  - RELEASE_WAIT:
    - sync_n==0: back to PRESSED (bounce rejected); hold_cnt resumes from frozen value.
    - Otherwise deb_cnt++.
    - When deb_cnt==DEBOUNCE_CYCLES-1: go to IDLE; pressed<=0, release_pulse<=1.
- Latency:
  - Edge e0 first samples bbutton low (stable thereafter).
  - pressed and press_pulse are high after edge e0+DEBOUNCE_CYCLES+2.
  - Release is symmetric.
- Strobe rules:
  - Every strobe is exactly one cycle wide.
  - press_pulse and release_pulse are never high in the same cycle.
  - At most one long_pulse per accepted press.
- pressed changes only in the same cycle as press_pulse or release_pulse.
- Reset mid-operation (any state): next cycle all outputs are 0 and FSM is IDLE. A button still held must be re-debounced from scratch, giving a fresh press_pulse.

Optional Feature:
- Macro BUTTON_LONG_PRESS_EN.
- Defined: hold_cnt, long_done and long_pulse logic are built as described.
- Undefined: hold_cnt and long_done are not instantiated, and long_pulse is tied to 0. All other behaviour is identical.

Decomposition:
- Package button_pkg holds:
  - typedef enum logic [1:0] btn_state_t {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT}
  - localparams DEFAULT_DEBOUNCE_CYCLES=270000 and DEFAULT_HOLD_CYCLES=27000000
- One sub-module: sync_2ff (param RESET_VAL=1; ports clk, rst, d, q) for the synchroniser.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, macro defined unless noted):
- Reset: rst=1 for 3 cycles with bbutton=0 -> all outputs 0. After release of rst, press_pulse fires at edge 6 (2 sync + 4 debounce) with pressed=1.
- Clean press/release: bbutton=0 from edge 10 -> press_pulse at edge 16. bbutton=1 from edge 40 -> release_pulse at edge 46, pressed=0 at the same edge.
- Bounce rejection: bbutton toggles 0/1 every 2 cycles for 30 cycles, then stays 1 -> no strobes, pressed stays 0. Then low for 3 cycles only -> no strobe.
- Long press: hold bbutton=0 for 60 cycles -> exactly one long_pulse, 20 cycles after press_pulse. Release bounce of 2 cycles mid-hold -> no release_pulse, no second long_pulse.
- Mid-operation reset: rst pulse 1 cycle while in PRESSED with bbutton still 0 -> pressed=0 next cycle, then new press_pulse 6 cycles after rst deasserts.
- Macro undefined: repeat the long-press case -> long_pulse never asserts; press/release timing unchanged.

Source files
------------

// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types and default timing for the button conditioning stage
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 270000;
    localparam int DEFAULT_HOLD_CYCLES     = 27000000;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous bit
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - sync + debounce of active-low button, press/release/long strobes
// Long-press detection is built only when BUTTON_LONG_PRESS_EN is defined.
module button_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic bbutton,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_param
        $error("button_debounce: DEBOUNCE_CYCLES and HOLD_CYCLES must be >= 1");
    end

    logic          sync_n;
    btn_state_t    state, state_nxt;
    logic [DW-1:0] deb_cnt, deb_cnt_nxt;
    logic          press_nxt, release_nxt, pressed_nxt;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bbutton),
        .q   (sync_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            deb_cnt       <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            deb_cnt       <= deb_cnt_nxt;
            pressed       <= pressed_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

    // A level going back to its old value during a wait state is a bounce and is dropped.
    always_comb begin
        state_nxt   = state;
        deb_cnt_nxt = deb_cnt;
        case (state)
            IDLE: begin
                if (!sync_n) begin
                    state_nxt   = PRESS_WAIT;
                    deb_cnt_nxt = '0;
                end
            end
            PRESS_WAIT: begin
                if (sync_n)                   state_nxt   = IDLE;
                else if (deb_cnt == DEB_LAST) state_nxt   = PRESSED;
                else                          deb_cnt_nxt = deb_cnt + DW'(1);
            end
            PRESSED: begin
                if (sync_n) begin
                    state_nxt   = RELEASE_WAIT;
                    deb_cnt_nxt = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!sync_n)                  state_nxt   = PRESSED;
                else if (deb_cnt == DEB_LAST) state_nxt   = IDLE;
                else                          deb_cnt_nxt = deb_cnt + DW'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        press_nxt   = (state == PRESS_WAIT)   && !sync_n && (deb_cnt == DEB_LAST);
        release_nxt = (state == RELEASE_WAIT) &&  sync_n && (deb_cnt == DEB_LAST);
        pressed_nxt = pressed;
        if (press_nxt)   pressed_nxt = 1'b1;
        if (release_nxt) pressed_nxt = 1'b0;
    end

`ifdef BUTTON_LONG_PRESS_EN
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

    logic [HW-1:0] hold_cnt;
    logic          long_done;

    // hold_cnt only advances in PRESSED, so it stays frozen across a release bounce.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt   <= '0;
            long_done  <= 1'b0;
            long_pulse <= 1'b0;
        end else begin
            long_pulse <= 1'b0;
            if (press_nxt) begin
                hold_cnt  <= '0;
                long_done <= 1'b0;
            end else if (state == PRESSED) begin
                if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HW'(1);
                if (hold_cnt == HOLD_LAST && !long_done) begin
                    long_pulse <= 1'b1;
                    long_done  <= 1'b1;
                end
            end
        end
    end
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - scoreboard bench for button_debounce (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20)
module tb_button_debounce;

    localparam int D   = 4;
    localparam int H   = 20;
    localparam int LAT = D + 3;
    localparam int K_PRESS = 100000, K_REL = 200000, K_LONG = 300000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bbutton = 1'b0;
    logic pressed, press_pulse, release_pulse, long_pulse;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int obs_q[$];

    logic prev_pressed = 1'b0, prev_press = 1'b0, prev_rel = 1'b0, prev_long = 1'b0, rst_q = 1'b1;

    button_debounce #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
        .clk           (clk),
        .rst           (rst),
        .bbutton       (bbutton),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Strobe-shape invariants, checked every cycle.
    always @(negedge clk) begin
        checks++;
        if (press_pulse === 1'b1 && release_pulse === 1'b1) begin
            errors++;
            $display("FAIL strobe_overlap cyc %0d press %b release %b want not both", cyc, press_pulse, release_pulse);
        end
        checks++;
        if ((press_pulse === 1'b1 && prev_press) || (release_pulse === 1'b1 && prev_rel) ||
            (long_pulse === 1'b1 && prev_long)) begin
            errors++;
            $display("FAIL strobe_width cyc %0d press %b release %b long %b want one-cycle strobes",
                     cyc, press_pulse, release_pulse, long_pulse);
        end
        checks++;
        if (!rst_q && pressed !== prev_pressed && press_pulse !== 1'b1 && release_pulse !== 1'b1) begin
            errors++;
            $display("FAIL pressed_change cyc %0d pressed %b want change only with a strobe", cyc, pressed);
        end
        prev_pressed = (pressed === 1'b1);
        prev_press   = (press_pulse === 1'b1);
        prev_rel     = (release_pulse === 1'b1);
        prev_long    = (long_pulse === 1'b1);
    end

    task automatic step();
        @(negedge clk);
        if (press_pulse === 1'b1)   obs_q.push_back(K_PRESS + cyc);
        if (release_pulse === 1'b1) obs_q.push_back(K_REL + cyc);
        if (long_pulse === 1'b1)    obs_q.push_back(K_LONG + cyc);
    endtask

    task automatic test_reset();
        int o, e;
        obs_q.delete(); exp_q.delete();
        rst = 1'b1; bbutton = 1'b0;
        repeat (3) begin
            step();
            checks++;
            if ({pressed, press_pulse, release_pulse, long_pulse} !== 4'b0) begin
                errors++;
                $display("FAIL reset_outputs got %b want 0000", {pressed, press_pulse, release_pulse, long_pulse});
            end
        end
        rst = 1'b0;
        exp_q.push_back(K_PRESS + cyc + LAT);
        repeat (12) step();
        checks++;
        if (pressed !== 1'b1) begin errors++; $display("FAIL reset_pressed got %b want 1", pressed); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL reset_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o != e) begin errors++; $display("FAIL reset_event got %0d want %0d", o, e); end
        end
    endtask

    task automatic test_clean();
        int o, e;
        obs_q.delete(); exp_q.delete();
        bbutton = 1'b1; exp_q.push_back(K_REL + cyc + LAT);
        repeat (12) step();
        checks++;
        if (pressed !== 1'b0) begin errors++; $display("FAIL clean_release1 pressed got %b want 0", pressed); end
        bbutton = 1'b0; exp_q.push_back(K_PRESS + cyc + LAT);
        repeat (12) step();
        checks++;
        if (pressed !== 1'b1) begin errors++; $display("FAIL clean_press pressed got %b want 1", pressed); end
        bbutton = 1'b1; exp_q.push_back(K_REL + cyc + LAT);
        repeat (12) step();
        checks++;
        if (pressed !== 1'b0) begin errors++; $display("FAIL clean_release2 pressed got %b want 0", pressed); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL clean_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o != e) begin errors++; $display("FAIL clean_event got %0d want %0d", o, e); end
        end
    endtask

    task automatic test_bounce();
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 30; i++) begin
            bbutton = ((i >> 1) & 1) ? 1'b1 : 1'b0;
            step();
        end
        bbutton = 1'b1; repeat (10) step();
        bbutton = 1'b0; repeat (3) step();
        bbutton = 1'b1; repeat (12) step();
        checks++;
        if (pressed !== 1'b0) begin errors++; $display("FAIL bounce_pressed got %b want 0", pressed); end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL bounce_events got %0d events (first %0d) want 0", obs_q.size(), obs_q[0]);
        end
    endtask

    task automatic test_long_press();
        int o, e, c;
        obs_q.delete(); exp_q.delete();
        c = cyc;
        exp_q.push_back(K_PRESS + c + LAT);
`ifdef BUTTON_LONG_PRESS_EN
        exp_q.push_back(K_LONG + c + LAT + H);
`endif
        for (int i = 0; i < 60; i++) begin
            bbutton = (i >= 40 && i < 42) ? 1'b1 : 1'b0;
            step();
        end
        checks++;
        if (pressed !== 1'b1) begin errors++; $display("FAIL long_held pressed got %b want 1", pressed); end
        bbutton = 1'b1; exp_q.push_back(K_REL + cyc + LAT);
        repeat (12) step();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL long_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o != e) begin errors++; $display("FAIL long_event got %0d want %0d", o, e); end
        end
    endtask

    task automatic test_mid_reset();
        int o, e;
        obs_q.delete(); exp_q.delete();
        bbutton = 1'b0; exp_q.push_back(K_PRESS + cyc + LAT);
        repeat (10) step();
        rst = 1'b1;
        step();
        checks++;
        if ({pressed, press_pulse, release_pulse, long_pulse} !== 4'b0) begin
            errors++;
            $display("FAIL midrst_outputs got %b want 0000", {pressed, press_pulse, release_pulse, long_pulse});
        end
        rst = 1'b0; exp_q.push_back(K_PRESS + cyc + LAT);
        repeat (12) step();
        checks++;
        if (pressed !== 1'b1) begin errors++; $display("FAIL midrst_repress got %b want 1", pressed); end
        bbutton = 1'b1; exp_q.push_back(K_REL + cyc + LAT);
        repeat (12) step();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL midrst_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o != e) begin errors++; $display("FAIL midrst_event got %0d want %0d", o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_bounce();
        test_long_press();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
